// File: rtl/wordline_register_file.sv
// 16x16 register file addressed by one-hot wordlines: two combinational read ports,
// one write port with write-to-read bypass, optional hardwired-zero R0, sticky select-error flag.
module wordline_register_file #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NREGS     = 16,
    parameter bit          REG0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREGS-1:0] SrcWordline1,
    input  logic [NREGS-1:0] SrcWordline2,
    input  logic [NREGS-1:0] DstWordline,
    input  logic             WriteReg,
    input  logic [WIDTH-1:0] DstData,
    input  logic             ErrClr,
    output logic [WIDTH-1:0] SrcData1,
    output logic [WIDTH-1:0] SrcData2,
    output logic             SelErr
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             sel_err_q;
    logic             sel_err_d;

    logic dst_onehot;
    logic wr_en;
    logic wr_err;
    logic rd1_multi;
    logic rd2_multi;

    assign dst_onehot = $onehot(DstWordline);
    assign wr_en      = WriteReg && dst_onehot && !(REG0_ZERO && DstWordline[0]);
    assign wr_err     = WriteReg && !dst_onehot;
    assign rd1_multi  = !$onehot0(SrcWordline1);
    assign rd2_multi  = !$onehot0(SrcWordline2);

    // regs_d is the write-through view of the array: it is both the next state and
    // the bypassed value each read port selects from, so bypass needs no separate compare.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (REG0_ZERO && i == 0) begin
                regs_d[i] = '0;
            end else if (wr_en && DstWordline[i]) begin
                regs_d[i] = DstData;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_comb begin
        SrcData1 = '0;
        SrcData2 = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (SrcWordline1[i]) SrcData1 = SrcData1 | regs_d[i];
            if (SrcWordline2[i]) SrcData2 = SrcData2 | regs_d[i];
        end
        if (rd1_multi) SrcData1 = '0;
        if (rd2_multi) SrcData2 = '0;
    end

    always_comb begin
        sel_err_d = sel_err_q;
        if (wr_err || rd1_multi || rd2_multi) begin
            sel_err_d = 1'b1;
        end else if (ErrClr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sel_err_q <= sel_err_d;
        end
    end

    assign SelErr = sel_err_q;

endmodule

// File: tb/tb_wordline_register_file.sv
// Self-checking bench for wordline_register_file: directed scenarios followed by
// randomized traffic checked against an index-based reference model.
module tb_wordline_register_file;

    localparam int unsigned W = 16;
    localparam int unsigned N = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw1, sw2, dw;
    logic         we;
    logic [W-1:0] dd;
    logic         clr;
    logic [W-1:0] rd1, rd2;
    logic         serr;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0] model [N];
    logic         model_err;

    wordline_register_file #(
        .WIDTH     (W),
        .NREGS     (N),
        .REG0_ZERO (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SrcWordline1 (sw1),
        .SrcWordline2 (sw2),
        .DstWordline  (dw),
        .WriteReg     (we),
        .DstData      (dd),
        .ErrClr       (clr),
        .SrcData1     (rd1),
        .SrcData2     (rd2),
        .SelErr       (serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) if (v[i]) c++;
        return c;
    endfunction

    function automatic int first_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Expected value of a read port given the current inputs and the model array.
    function automatic logic [W-1:0] exp_read(input logic [N-1:0] sel);
        int k;
        if (ones(sel) != 1) return '0;
        k = first_idx(sel);
        if (k == 0) return '0;
        if (we && ones(dw) == 1 && dw == sel) return dd;
        return model[k];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = '0;
        model_err = 1'b0;
    endtask

    // One cycle: drive after the falling edge, check reads, clock, then check SelErr.
    task automatic step(input logic [N-1:0] s1, input logic [N-1:0] s2, input logic [N-1:0] d,
                        input logic w, input logic [W-1:0] data, input logic c, input string tag);
        logic set_err;
        int   k;
        @(negedge clk);
        sw1 = s1; sw2 = s2; dw = d; we = w; dd = data; clr = c;
        #1;
        check({tag, "_rd1"}, rd1, exp_read(s1));
        check({tag, "_rd2"}, rd2, exp_read(s2));
        set_err = (w && ones(d) != 1) || ones(s1) > 1 || ones(s2) > 1;
        k = first_idx(d);
        @(posedge clk);
        #1;
        if (w && ones(d) == 1 && k != 0) model[k] = data;
        if (set_err) model_err = 1'b1;
        else if (c) model_err = 1'b0;
        check({tag, "_err"}, {15'd0, serr}, {15'd0, model_err});
    endtask

    initial begin
        logic [N-1:0] s1, s2, d;
        model_reset();
        rst_n = 1'b0;
        sw1 = 16'h0020; sw2 = 16'h0020; dw = '0; we = 1'b0; dd = '0; clr = 1'b0;
        #3;
        check("reset_rd1", rd1, 16'h0000);
        check("reset_rd2", rd2, 16'h0000);
        check("reset_err", {15'd0, serr}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        step(16'h0020, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0, "t1_r5");

        step(16'h0000, 16'h0000, 16'h0008, 1'b1, 16'hBEEF, 1'b0, "t2_wr");
        step(16'h0008, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "t2_rd");
        check("t2_r3_beef", rd1, 16'hBEEF);

        step(16'h0080, 16'h0080, 16'h0080, 1'b1, 16'h1234, 1'b0, "t3_byp");
        @(negedge clk);
        sw1 = 16'h0080; sw2 = 16'h0080; dw = 16'h0080; we = 1'b1; dd = 16'h5678; #1;
        check("t3_byp1_direct", rd1, 16'h5678);
        check("t3_byp2_direct", rd2, 16'h5678);
        we = 1'b0;
        model[7] = 16'h1234;

        step(16'h0001, 16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b0, "t4_r0w");
        step(16'h0001, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0, "t4_r0rd");
        check("t4_r0_zero", rd1, 16'h0000);
        check("t4_err0", {15'd0, serr}, 16'h0000);

        step(16'h0010, 16'h0000, 16'h0011, 1'b1, 16'hAAAA, 1'b0, "t5_mh");
        check("t5_err1", {15'd0, serr}, 16'h0001);
        step(16'h0010, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b1, "t5_clr");
        check("t5_cleared", {15'd0, serr}, 16'h0000);
        check("t5_r3_kept", rd2, 16'hBEEF);
        step(16'h0003, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "t5_setwins");
        check("t5_setwins_err", {15'd0, serr}, 16'h0001);
        step(16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, "t5_zhw");
        check("t5_zero_hot_write", {15'd0, serr}, 16'h0001);
        step(16'h0000, 16'h0000, 16'h0003, 1'b0, 16'h0000, 1'b1, "t5_noweidle");
        check("t5_idle_clears", {15'd0, serr}, 16'h0000);

        for (int i = 1; i < N; i++) begin
            d = '0; d[i] = 1'b1;
            step(16'h0000, 16'h0000, d, 1'b1, W'(16'h1000 + i * 16'h0111), 1'b0, "t6_fill");
        end
        step(16'h8000, 16'h0002, 16'h0000, 1'b0, 16'h0000, 1'b0, "t6_chk");
        @(negedge clk);
        dw = 16'h0004; we = 1'b1; dd = 16'hDEAD;
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 1; i < N; i++) begin
            s1 = '0; s1[i] = 1'b1;
            sw1 = s1; sw2 = s1; we = 1'b0;
            #1;
            check("t6_rst_rd1", rd1, 16'h0000);
            check("t6_rst_rd2", rd2, 16'h0000);
        end
        check("t6_rst_err", {15'd0, serr}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0004, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0, "t6_after");

        for (int n = 0; n < 300; n++) begin
            logic [N-1:0] sel [3];
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 9))
                    0:       sel[p] = '0;
                    1:       sel[p] = N'($urandom);
                    default: begin sel[p] = '0; sel[p][$urandom_range(0, N - 1)] = 1'b1; end
                endcase
            end
            if ($urandom_range(0, 3) == 0) sel[0] = sel[2];
            if ($urandom_range(0, 4) == 0) sel[1] = sel[2];
            step(sel[0], sel[1], sel[2], $urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 4) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
